// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MIPS data port and a burst DMA requester.
// The CPU has priority, and a bounded-wait counter keeps the DMA from starving.
module dmem_arbiter #(
  parameter int BURST_W  = 6,
  parameter int MAX_WAIT = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               cpu_stall,
  input  logic               dma_req,
  input  logic               dma_we,
  input  logic [31:0]        dma_base,
  input  logic [BURST_W-1:0] dma_len,
  input  logic [31:0]        dma_wdata,
  output logic [31:0]        dma_rdata,
  output logic               dma_valid,
  output logic               dma_done,
  output logic               dma_busy,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               MEMWRITE,
  input  logic [31:0]        mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, DMA = 2'd2} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t               state;
  logic [7:0]           wait_cnt;
  logic [BURST_W-1:0]   beat_cnt;
  logic [BURST_W-1:0]   len;
  logic [31:0]          base;
  logic                 we;

  logic                 dma_win;
  logic                 last_beat;
  logic [31:0]          beat_off;
  logic                 mem_we;
  logic                 stall;
  logic                 valid;
  logic                 done;
  logic                 busy;

  assign dma_win   = dma_req && (!cpu_req || (wait_cnt == WAIT_LIMIT));
  assign last_beat = (beat_cnt == (len - BURST_W'(1)));
  assign beat_off  = 32'(beat_cnt) << 2;

  // Arbitration state, starvation counter and latched burst descriptor.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!dma_req) begin
            wait_cnt <= 8'd0;
          end else if (dma_win) begin
            base     <= dma_base & 32'hFFFF_FFFC;
            len      <= dma_len;
            we       <= dma_we;
            wait_cnt <= 8'd0;
            state    <= GRANT;
          end else if (wait_cnt != WAIT_LIMIT) begin
            // Both requesting and the CPU won: DMA waited one more cycle.
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        GRANT: begin
          beat_cnt <= '0;
          state    <= (len == '0) ? IDLE : DMA;
        end
        DMA: begin
          if (last_beat) begin
            state <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + BURST_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory steering and handshake outputs for the current owner.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 1'b0;
    stall     = 1'b0;
    valid     = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        mem_we = cpu_req && !dma_win && cpu_we;
        stall  = cpu_req && dma_win;
      end
      GRANT: begin
        busy  = 1'b1;
        stall = cpu_req;
        done  = (len == '0);
      end
      DMA: begin
        mem_addr  = base + beat_off;
        mem_wdata = dma_wdata;
        mem_we    = we;
        valid     = 1'b1;
        busy      = 1'b1;
        stall     = cpu_req;
        done      = last_beat;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  assign MEMWRITE  = RESET ? 1'b0 : mem_we;
  assign cpu_stall = RESET ? 1'b0 : stall;
  assign dma_valid = RESET ? 1'b0 : valid;
  assign dma_done  = RESET ? 1'b0 : done;
  assign dma_busy  = RESET ? 1'b0 : busy;
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a
// beat scoreboard checked whenever the arbiter reports a DMA beat.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_base;
  logic [5:0]  dma_len;
  logic [31:0] dma_wdata, dma_rdata;
  logic        dma_valid, dma_done, dma_busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        MEMWRITE;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [0:255];

  dmem_arbiter #(.BURST_W(6), .MAX_WAIT(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_valid(dma_valid),
    .dma_done(dma_done), .dma_busy(dma_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .MEMWRITE(MEMWRITE), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge CLK) if (MEMWRITE) mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every reported beat must match the oldest expected beat.
  always @(negedge CLK) begin
    if (dma_valid) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("beat_addr", mem_addr, b.addr);
        chk("beat_we", {31'd0, MEMWRITE}, {31'd0, b.we});
        chk("beat_data", b.we ? mem_wdata : dma_rdata, b.data);
      end
    end
  end

  task automatic push_beats(input logic [31:0] a0, input int n, input logic w, input logic [31:0] d0);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.addr = a0 + 32'(i * 4);
      b.we   = w;
      b.data = d0 + 32'(i);
      exp_q.push_back(b);
    end
  endtask

  // Uncontended burst: request, GRANT bubble, len beats, back to IDLE.
  task automatic burst(input logic [31:0] base, input logic [5:0] len, input logic w,
                       input logic [31:0] d0, input logic [31:0] exp_a0);
    dma_req = 1'b1; dma_we = w; dma_base = base; dma_len = len;
    #3;
    chk("req_busy", {31'd0, dma_busy}, 32'd0);
    chk("req_memwrite", {31'd0, MEMWRITE}, 32'd0);
    push_beats(exp_a0, int'(len), w, d0);
    cyc();
    dma_req = 1'b0;
    #3;
    chk("grant_busy", {31'd0, dma_busy}, 32'd1);
    chk("grant_memwrite", {31'd0, MEMWRITE}, 32'd0);
    chk("grant_valid", {31'd0, dma_valid}, 32'd0);
    chk("grant_done", {31'd0, dma_done}, (len == 6'd0) ? 32'd1 : 32'd0);
    cyc();
    for (int i = 0; i < int'(len); i++) begin
      dma_wdata = d0 + 32'(i);
      #3;
      chk("beat_valid", {31'd0, dma_valid}, 32'd1);
      chk("beat_done", {31'd0, dma_done}, (i == int'(len) - 1) ? 32'd1 : 32'd0);
      cyc();
    end
    #3;
    chk("after_busy", {31'd0, dma_busy}, 32'd0);
    chk("after_done", {31'd0, dma_done}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b1; dma_we = 1'b0; dma_base = 32'h0; dma_len = 6'd0; dma_wdata = 32'h0;
    cyc();
    #3;
    chk("rst_memwrite", {31'd0, MEMWRITE}, 32'd0);
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_busy", {31'd0, dma_busy}, 32'd0);
    chk("rst_valid", {31'd0, dma_valid}, 32'd0);
    cyc();
    RESET = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; dma_req = 1'b0;

    // Uncontended CPU store then load.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #3;
    chk("cpu_st_stall", {31'd0, cpu_stall}, 32'd0);
    chk("cpu_st_memwrite", {31'd0, MEMWRITE}, 32'd1);
    chk("cpu_st_addr", mem_addr, 32'h10);
    cyc();
    cpu_we = 1'b0;
    #3;
    chk("cpu_ld_stall", {31'd0, cpu_stall}, 32'd0);
    chk("cpu_ld_memwrite", {31'd0, MEMWRITE}, 32'd0);
    chk("cpu_ld_rdata", cpu_rdata, 32'hDEADBEEF);
    cyc();
    cpu_req = 1'b0;

    burst(32'h20, 6'd4, 1'b1, 32'd1, 32'h20);
    burst(32'h20, 6'd4, 1'b0, 32'd1, 32'h20);

    // Starvation bound: CPU served MAX_WAIT cycles, then DMA takes over.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_base = 32'h20; dma_len = 6'd2;
    for (int k = 0; k < 8; k++) begin
      #3;
      chk("starve_cpu_stall", {31'd0, cpu_stall}, 32'd0);
      chk("starve_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      cyc();
    end
    #3;
    chk("starve_win_stall", {31'd0, cpu_stall}, 32'd1);
    chk("starve_win_busy", {31'd0, dma_busy}, 32'd0);
    push_beats(32'h20, 2, 1'b0, 32'd1);
    cyc();
    #3;
    chk("starve_grant_stall", {31'd0, cpu_stall}, 32'd1);
    chk("starve_grant_busy", {31'd0, dma_busy}, 32'd1);
    cyc();
    #3;
    chk("starve_beat0_stall", {31'd0, cpu_stall}, 32'd1);
    cyc();
    #3;
    chk("starve_beat1_stall", {31'd0, cpu_stall}, 32'd1);
    chk("starve_beat1_done", {31'd0, dma_done}, 32'd1);
    cyc();
    #3;
    chk("starve_back_stall", {31'd0, cpu_stall}, 32'd0);
    chk("starve_back_busy", {31'd0, dma_busy}, 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0;
    cyc();

    burst(32'h40, 6'd0, 1'b1, 32'h0, 32'h40);
    burst(32'hFFFFFFFC, 6'd2, 1'b1, 32'h55, 32'hFFFFFFFC);
    burst(32'h23, 6'd1, 1'b1, 32'h77, 32'h20);

    // Reset on the second beat of a 6-word write abandons the burst.
    dma_req = 1'b1; dma_we = 1'b1; dma_base = 32'h80; dma_len = 6'd6;
    push_beats(32'h80, 1, 1'b1, 32'h100);
    cyc();
    dma_req = 1'b0;
    cyc();
    dma_wdata = 32'h100;
    #3;
    chk("rb_beat0_done", {31'd0, dma_done}, 32'd0);
    cyc();
    RESET = 1'b1; dma_wdata = 32'h101;
    #3;
    chk("rb_rst_valid", {31'd0, dma_valid}, 32'd0);
    chk("rb_rst_done", {31'd0, dma_done}, 32'd0);
    chk("rb_rst_busy", {31'd0, dma_busy}, 32'd0);
    chk("rb_rst_memwrite", {31'd0, MEMWRITE}, 32'd0);
    cyc();
    RESET = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    #3;
    chk("rb_idle_busy", {31'd0, dma_busy}, 32'd0);
    chk("rb_idle_done", {31'd0, dma_done}, 32'd0);
    chk("rb_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rb_cpu_rdata", cpu_rdata, 32'h100);
    cyc();
    cpu_req = 1'b0;
    cyc();
    cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
